// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_ctrl_pkg;

   localparam int REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } stall_state_e;

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall / flush / freeze event counters, wrapping modulo 2^CNT_W.
module hazard_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall_evt,
   input  logic             flush_evt,
   input  logic             freeze_evt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] freeze_cnt
);

   logic [2:0]            evt;
   logic [2:0][CNT_W-1:0] cnt_all;

   assign evt = {freeze_evt, flush_evt, stall_evt};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_reg <= '0;
            end else if (evt[gi]) begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end

         assign cnt_all[gi] = cnt_reg;
      end
   endgenerate

   assign stall_cnt  = cnt_all[0];
   assign flush_cnt  = cnt_all[1];
   assign freeze_cnt = cnt_all[2];

endmodule

// File: rtl/pipeline_stall_controller.sv
// Load-use stall / branch flush / dmem freeze sequencer for the 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add the stall/flush/freeze performance counters.
module pipeline_stall_controller
   import hazard_ctrl_pkg::*;
#(
   parameter int LOAD_USE_STALL = 1,
   parameter int CNT_W          = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [REG_IDX_W-1:0] IFID_rs1,
   input  logic [REG_IDX_W-1:0] IFID_rs2,
   input  logic                 IFID_uses_rs2,
   input  logic [REG_IDX_W-1:0] IDEX_rd,
   input  logic                 IDEX_MemRead,
   input  logic                 branch_taken,
   input  logic                 EXMEM_MemAccess,
   input  logic                 dmem_ready,
   output logic                 PCWrite,
   output logic                 IFID_Write,
   output logic                 IFID_Flush,
   output logic                 IDEX_mux_out,
   output logic                 IDEX_Flush,
   output logic                 EXMEM_Write,
   output logic                 MEMWB_bubble
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt,
   output logic [CNT_W-1:0]     freeze_cnt
`endif
);

   localparam int LU_CNT_W = $clog2(LOAD_USE_STALL + 1);
   localparam logic [LU_CNT_W-1:0] LU_INIT = LU_CNT_W'(LOAD_USE_STALL - 1);
   localparam logic [LU_CNT_W-1:0] LU_LAST = LU_CNT_W'(1);

   generate
      if (LOAD_USE_STALL < 1 || LOAD_USE_STALL > 15 || CNT_W < 1) begin : g_bad_param
         $error("pipeline_stall_controller: LOAD_USE_STALL must be 1..15 and CNT_W >= 1");
      end
   endgenerate

   stall_state_e        state_reg, state_next;
   logic [LU_CNT_W-1:0] lu_cnt_reg, lu_cnt_next;
   logic                lu_hit;
   logic                frz;

   assign lu_hit = IDEX_MemRead && (IDEX_rd != REG_X0) &&
                   ((IDEX_rd == IFID_rs1) || (IFID_uses_rs2 && (IDEX_rd == IFID_rs2)));
   assign frz    = EXMEM_MemAccess && !dmem_ready;

   always_comb begin
      PCWrite      = 1'b1;
      IFID_Write   = 1'b1;
      IFID_Flush   = 1'b0;
      IDEX_mux_out = 1'b1;
      IDEX_Flush   = 1'b0;
      EXMEM_Write  = 1'b1;
      MEMWB_bubble = 1'b0;
      state_next   = state_reg;
      lu_cnt_next  = lu_cnt_reg;

      if (frz) begin
         // Whole front end holds; MEM/WB gets a bubble so WB does not replay.
         PCWrite      = 1'b0;
         IFID_Write   = 1'b0;
         EXMEM_Write  = 1'b0;
         MEMWB_bubble = 1'b1;
      end else if (branch_taken) begin
         IFID_Flush  = 1'b1;
         IDEX_Flush  = 1'b1;
         state_next  = RUN;
         lu_cnt_next = '0;
      end else if (state_reg == LU_STALL) begin
         PCWrite      = 1'b0;
         IFID_Write   = 1'b0;
         IDEX_mux_out = 1'b0;
         lu_cnt_next  = lu_cnt_reg - 1'b1;
         if (lu_cnt_reg == LU_LAST) begin
            state_next = RUN;
         end
      end else if (lu_hit) begin
         PCWrite      = 1'b0;
         IFID_Write   = 1'b0;
         IDEX_mux_out = 1'b0;
         if (LOAD_USE_STALL > 1) begin
            state_next  = LU_STALL;
            lu_cnt_next = LU_INIT;
         end
      end

      if (!reset_n) begin
         PCWrite      = 1'b0;
         IFID_Write   = 1'b0;
         IFID_Flush   = 1'b0;
         IDEX_mux_out = 1'b0;
         IDEX_Flush   = 1'b0;
         EXMEM_Write  = 1'b0;
         MEMWB_bubble = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= RUN;
         lu_cnt_reg <= '0;
      end else begin
         state_reg  <= state_next;
         lu_cnt_reg <= lu_cnt_next;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counters #(
      .CNT_W(CNT_W)
   ) u_perf (
      .clk       (clk),
      .reset_n   (reset_n),
      .stall_evt (!IDEX_mux_out && !frz),
      .flush_evt (IFID_Flush),
      .freeze_evt(frz),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt),
      .freeze_cnt(freeze_cnt)
   );
`else
   // Counter ports and logic are absent in this build.
`endif

endmodule
